coin_scheduler: RTL and testbench

Frame-rate scheduler for the falling-coin layer. Once per frame it walks four coin slots, erases and redraws each live coin one step lower, detects collection by the player and misses at the screen bottom, and periodically spawns a new coin. It requests lane x positions from the three-lane track generator through that generator's `go` input. It is the single owner of the shared pixel plotter for coin graphics and serialises all erase and draw jobs onto it through a req/done handshake.

---
 rtl/coin_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_coin_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_scheduler.sv
// Falling-coin frame scheduler: once per accepted frame it walks four coin slots,
// erases and redraws each live coin one step lower, detects collection and misses,
// and periodically spawns a coin in the lane supplied by the track generator.
module coin_scheduler #(
    parameter int unsigned SPAWN_PERIOD = 20,
    parameter int unsigned Y_STEP       = 1,
    parameter int unsigned Y_MAX        = 119,
    parameter int unsigned PLAYER_Y     = 110
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable_i,
    input  logic       frame_tick_i,
    input  logic [7:0] track_x_i,
    input  logic [7:0] player_x_i,
    input  logic       draw_done_i,
    output logic       gen_go_o,
    output logic       draw_req_o,
    output logic [7:0] draw_x_o,
    output logic [6:0] draw_y_o,
    output logic       draw_erase_o,
    output logic [3:0] coin_active_o,
    output logic       coin_collected_o,
    output logic       coin_missed_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        StIdle, StScan, StErase, StEraseWait, StMove, StDraw, StDrawWait, StSpawn
    } state_e;

    localparam logic [7:0] CntReload = 8'(SPAWN_PERIOD - 1);

    state_e          state_q, state_d, adv_state;
    logic [1:0]      slot_q, slot_d, free_idx;
    logic [3:0]      active_q, active_d;
    logic [3:0][7:0] x_q, x_d;
    logic [3:0][6:0] y_q, y_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic            spawning_q, spawning_d;
    logic            free_found, hit_player, past_bottom;
    logic [7:0]      ny;

    logic            gen_go_q, gen_go_d;
    logic            draw_req_q, draw_req_d;
    logic [7:0]      draw_x_q, draw_x_d;
    logic [6:0]      draw_y_q, draw_y_d;
    logic            draw_erase_q, draw_erase_d;
    logic            collected_q, collected_d;
    logic            missed_q, missed_d;
    logic            busy_q, busy_d;

    // State, slot storage and registered outputs; reset abandons any plotter job
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            active_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= CntReload;
            pending_q    <= 1'b0;
            spawning_q   <= 1'b0;
            gen_go_q     <= 1'b0;
            draw_req_q   <= 1'b0;
            draw_x_q     <= '0;
            draw_y_q     <= '0;
            draw_erase_q <= 1'b0;
            collected_q  <= 1'b0;
            missed_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            active_q     <= active_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            spawning_q   <= spawning_d;
            gen_go_q     <= gen_go_d;
            draw_req_q   <= draw_req_d;
            draw_x_q     <= draw_x_d;
            draw_y_q     <= draw_y_d;
            draw_erase_q <= draw_erase_d;
            collected_q  <= collected_d;
            missed_q     <= missed_d;
            busy_q       <= busy_d;
        end
    end

    // Shared decode: moved row (8 bits so it never wraps), outcomes, lowest free slot
    always_comb begin
        ny          = {1'b0, y_q[slot_q]} + 8'(Y_STEP);
        hit_player  = (ny == 8'(PLAYER_Y)) && (x_q[slot_q] == player_x_i);
        past_bottom = ny > 8'(Y_MAX);
        free_found  = 1'b0;
        free_idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
        end
        adv_state = (slot_q == 2'd3) ? (pending_q ? StSpawn : StIdle) : StScan;
    end

    // Next-state and slot datapath
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        active_d   = active_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        spawning_d = spawning_q;
        unique case (state_q)
            StIdle: begin
                if (frame_tick_i && enable_i) begin
                    state_d    = StScan;
                    slot_d     = 2'd0;
                    spawning_d = 1'b0;
                    if (cnt_q == 8'd0) pending_d = 1'b1;
                    else               cnt_d     = cnt_q - 8'd1;
                end
            end
            StScan: begin
                if (active_q[slot_q]) begin
                    state_d = StErase;
                end else begin
                    slot_d  = slot_q + 2'd1;
                    state_d = adv_state;
                end
            end
            StErase:     state_d = StEraseWait;
            StEraseWait: if (draw_done_i) state_d = StMove;
            StMove: begin
                if (hit_player || past_bottom) begin
                    active_d[slot_q] = 1'b0;
                    x_d[slot_q]      = '0;
                    y_d[slot_q]      = '0;
                    slot_d           = slot_q + 2'd1;
                    state_d          = adv_state;
                end else begin
                    y_d[slot_q] = ny[6:0];
                    state_d     = StDraw;
                end
            end
            StDraw: state_d = StDrawWait;
            StDrawWait: begin
                if (draw_done_i) begin
                    if (spawning_q) begin
                        spawning_d = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        slot_d  = slot_q + 2'd1;
                        state_d = adv_state;
                    end
                end
            end
            StSpawn: begin
                pending_d = 1'b0;
                if (free_found) begin
                    active_d[free_idx] = 1'b1;
                    x_d[free_idx]      = track_x_i;
                    y_d[free_idx]      = '0;
                    cnt_d              = CntReload;
                    slot_d             = free_idx;
                    spawning_d         = 1'b1;
                    state_d            = StDraw;
                end else begin
                    // Counter stays at zero so the spawn is retried next frame
                    cnt_d   = 8'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        gen_go_d     = 1'b0;
        collected_d  = 1'b0;
        missed_d     = 1'b0;
        draw_req_d   = draw_req_q;
        draw_x_d     = draw_x_q;
        draw_y_d     = draw_y_q;
        draw_erase_d = draw_erase_q;
        busy_d       = (state_d != StIdle);
        unique case (state_q)
            StErase, StDraw: begin
                draw_req_d   = 1'b1;
                draw_x_d     = x_q[slot_q];
                draw_y_d     = y_q[slot_q];
                draw_erase_d = (state_q == StErase);
            end
            StEraseWait, StDrawWait: if (draw_done_i) draw_req_d = 1'b0;
            StMove: begin
                if (hit_player)       collected_d = 1'b1;
                else if (past_bottom) missed_d    = 1'b1;
            end
            StSpawn: gen_go_d = free_found;
            default: ;
        endcase
    end

    assign gen_go_o         = gen_go_q;
    assign draw_req_o       = draw_req_q;
    assign draw_x_o         = draw_x_q;
    assign draw_y_o         = draw_y_q;
    assign draw_erase_o     = draw_erase_q;
    assign coin_active_o    = active_q;
    assign coin_collected_o = collected_q;
    assign coin_missed_o    = missed_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_coin_scheduler.sv
// Directed bench for coin_scheduler: SPAWN_PERIOD=2, plotter latency 3, lanes 30/70/110.
module tb_coin_scheduler;

    localparam int L = 3;
    localparam int FrameBound = 400;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable_i;
    logic       frame_tick_i;
    logic [7:0] track_x_i;
    logic [7:0] player_x_i;
    logic       draw_done_i;
    logic       gen_go_o;
    logic       draw_req_o;
    logic [7:0] draw_x_o;
    logic [6:0] draw_y_o;
    logic       draw_erase_o;
    logic [3:0] coin_active_o;
    logic       coin_collected_o;
    logic       coin_missed_o;
    logic       busy_o;

    coin_scheduler #(
        .SPAWN_PERIOD(2),
        .Y_STEP      (1),
        .Y_MAX       (119),
        .PLAYER_Y    (110)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable_i        (enable_i),
        .frame_tick_i    (frame_tick_i),
        .track_x_i       (track_x_i),
        .player_x_i      (player_x_i),
        .draw_done_i     (draw_done_i),
        .gen_go_o        (gen_go_o),
        .draw_req_o      (draw_req_o),
        .draw_x_o        (draw_x_o),
        .draw_y_o        (draw_y_o),
        .draw_erase_o    (draw_erase_o),
        .coin_active_o   (coin_active_o),
        .coin_collected_o(coin_collected_o),
        .coin_missed_o   (coin_missed_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Per-frame capture
    logic [7:0] job_x[$];
    logic [6:0] job_y[$];
    logic       job_e[$];
    int n_gen, n_coll, n_miss;
    // Whole-run tallies
    int n_unstable = 0;
    int n_excl     = 0;
    int n_timeout  = 0;
    logic prev_gen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_job(input string tag, input int idx, input int x, input int y,
                             input int e);
        logic [31:0] obs;
        obs = 32'hffff_ffff;
        if (idx < job_x.size()) obs = {16'd0, job_x[idx], job_y[idx], job_e[idx]};
        check(tag, obs, {16'd0, 8'(x), 7'(y), 1'(e)});
    endtask

    function automatic logic [7:0] next_lane(input logic [7:0] x);
        return (x == 8'd30) ? 8'd70 : (x == 8'd70) ? 8'd110 : 8'd30;
    endfunction

    // One frame: tick, then act as plotter (latency L) and track generator until idle
    task automatic run_frame(input int extra_tick_at, input int enable_drop_at);
        int cyc;
        int age;
        logic [15:0] held;
        job_x.delete();
        job_y.delete();
        job_e.delete();
        n_gen  = 0;
        n_coll = 0;
        n_miss = 0;
        cyc    = 0;
        age    = 0;
        held   = '0;
        @(negedge clk);
        frame_tick_i = 1'b1;
        @(negedge clk);
        frame_tick_i = 1'b0;
        check("frame_accept_busy", 32'(busy_o), 32'd1);
        forever begin
            if (gen_go_o) n_gen++;
            if (coin_collected_o) n_coll++;
            if (coin_missed_o) n_miss++;
            if ($countones({gen_go_o, coin_collected_o, coin_missed_o}) > 1) n_excl++;
            if (prev_gen && !gen_go_o) track_x_i = next_lane(track_x_i);
            prev_gen = gen_go_o;
            if (draw_done_i) draw_done_i = 1'b0;
            if (draw_req_o) begin
                if (age == 0) begin
                    job_x.push_back(draw_x_o);
                    job_y.push_back(draw_y_o);
                    job_e.push_back(draw_erase_o);
                    held = {draw_x_o, draw_y_o, draw_erase_o};
                end else if (held != {draw_x_o, draw_y_o, draw_erase_o}) begin
                    n_unstable++;
                end
                age++;
                if (age == L) draw_done_i = 1'b1;
            end else begin
                age = 0;
            end
            if (!busy_o) break;
            if (cyc >= FrameBound) begin
                n_timeout++;
                check("frame_bound", 32'(busy_o), 32'd0);
                break;
            end
            frame_tick_i = (cyc == extra_tick_at);
            if (cyc == enable_drop_at) enable_i = 1'b0;
            @(negedge clk);
            cyc++;
        end
        frame_tick_i = 1'b0;
        draw_done_i  = 1'b0;
        enable_i     = 1'b1;
        if (n_timeout > 3) begin
            $display("FAIL frame_bound: too many frames never returned to idle");
            $fatal(1, "aborting");
        end
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame(-1, -1);
    endtask

    initial begin
        reset_n      = 1'b0;
        enable_i     = 1'b1;
        frame_tick_i = 1'b0;
        track_x_i    = 8'd30;
        player_x_i   = 8'd0;
        draw_done_i  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_draw_req", 32'(draw_req_o), 32'd0);
        check("rst_active", 32'(coin_active_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_pulses", 32'({gen_go_o, coin_collected_o, coin_missed_o}), 32'd0);
        check("rst_job", 32'({draw_x_o, draw_y_o, draw_erase_o}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Tick with enable low is ignored and must not touch the spawn counter
        enable_i     = 1'b0;
        frame_tick_i = 1'b1;
        @(negedge clk);
        frame_tick_i = 1'b0;
        check("tick_gated_busy", 32'(busy_o), 32'd0);
        enable_i = 1'b1;

        // Frame 1: counter 1 -> 0, nothing to do
        run_frame(-1, -1);
        check("f1_gen", 32'(n_gen), 32'd0);
        check("f1_jobs", 32'(job_x.size()), 32'd0);

        // Frame 2: spawn into slot 0 at lane 30
        run_frame(-1, -1);
        check("f2_gen", 32'(n_gen), 32'd1);
        check("f2_jobs", 32'(job_x.size()), 32'd1);
        check_job("f2_spawn_draw", 0, 30, 0, 0);
        check("f2_active", 32'(coin_active_o), 32'h1);

        // Frame 3: a second tick mid-pass is dropped
        run_frame(5, -1);
        check("f3_gen", 32'(n_gen), 32'd0);
        check("f3_jobs", 32'(job_x.size()), 32'd2);
        check_job("f3_erase", 0, 30, 0, 1);
        check_job("f3_draw", 1, 30, 1, 0);
        repeat (3) @(negedge clk);
        check("f3_tick_dropped", 32'(busy_o), 32'd0);

        // Frame 4: spawn slot 1 at lane 70
        run_frame(-1, -1);
        check("f4_gen", 32'(n_gen), 32'd1);
        check_job("f4_spawn_draw", 2, 70, 0, 0);
        check("f4_active", 32'(coin_active_o), 32'h3);

        run_frames(3);

        // Frame 8: enable dropped mid-pass; slot 0 y 5 -> 6, slot 3 spawned at lane 30
        run_frame(-1, 4);
        check("f8_jobs", 32'(job_x.size()), 32'd7);
        check_job("f8_erase_y5", 0, 30, 5, 1);
        check_job("f8_draw_y6", 1, 30, 6, 0);
        check_job("f8_slot2_draw", 5, 110, 2, 0);
        check_job("f8_spawn_draw", 6, 30, 0, 0);
        check("f8_gen", 32'(n_gen), 32'd1);
        check("f8_active", 32'(coin_active_o), 32'hf);

        // Frames 9-11: all slots live, no spawn possible
        run_frame(-1, -1);
        check("f9_gen", 32'(n_gen), 32'd0);
        run_frame(-1, -1);
        check("f10_gen_full", 32'(n_gen), 32'd0);
        run_frame(-1, -1);
        check("f11_gen_full", 32'(n_gen), 32'd0);

        run_frames(102);

        // Frame 114: slot 1 (x=70) reaches row 110 but player is in lane 30
        player_x_i = 8'd30;
        run_frame(-1, -1);
        player_x_i = 8'd0;
        check("f114_jobs", 32'(job_x.size()), 32'd8);
        check_job("f114_erase", 2, 70, 109, 1);
        check_job("f114_draw_110", 3, 70, 110, 0);
        check("f114_coll", 32'(n_coll), 32'd0);

        run_frames(3);

        // Frame 118: slot 3 (x=30) collected at row 110, freed slot respawned at lane 70
        player_x_i = 8'd30;
        run_frame(-1, -1);
        player_x_i = 8'd0;
        check("f118_jobs", 32'(job_x.size()), 32'd8);
        check_job("f118_erase_109", 6, 30, 109, 1);
        check_job("f118_spawn_draw", 7, 70, 0, 0);
        check("f118_coll", 32'(n_coll), 32'd1);
        check("f118_miss", 32'(n_miss), 32'd0);
        check("f118_gen", 32'(n_gen), 32'd1);
        check("f118_active", 32'(coin_active_o), 32'hf);

        run_frames(2);
        run_frame(-1, -1);
        check_job("f121_draw_119", 1, 30, 119, 0);
        check("f121_gen", 32'(n_gen), 32'd0);

        // Frame 122: slot 0 falls past the bottom, then respawns at lane 110
        run_frame(-1, -1);
        check("f122_jobs", 32'(job_x.size()), 32'd8);
        check_job("f122_erase_119", 0, 30, 119, 1);
        check_job("f122_next_slot", 1, 70, 117, 1);
        check_job("f122_spawn_draw", 7, 110, 0, 0);
        check("f122_miss", 32'(n_miss), 32'd1);
        check("f122_coll", 32'(n_coll), 32'd0);
        check("f122_gen", 32'(n_gen), 32'd1);
        check("f122_active", 32'(coin_active_o), 32'hf);

        check("req_fields_stable", 32'(n_unstable), 32'd0);
        check("pulses_exclusive", 32'(n_excl), 32'd0);
        check("frames_bounded", 32'(n_timeout), 32'd0);

        // Reset while a plotter job is outstanding
        @(negedge clk);
        frame_tick_i = 1'b1;
        @(negedge clk);
        frame_tick_i = 1'b0;
        for (int i = 0; i < 50 && !draw_req_o; i++) @(negedge clk);
        check("rst_mid_req_seen", 32'(draw_req_o), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_mid_draw_req", 32'(draw_req_o), 32'd0);
        check("rst_mid_active", 32'(coin_active_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);

        // Counter reloaded: spawn again on the second frame, next lane is 30
        run_frame(-1, -1);
        check("post_rst_f1_gen", 32'(n_gen), 32'd0);
        run_frame(-1, -1);
        check("post_rst_f2_gen", 32'(n_gen), 32'd1);
        check_job("post_rst_spawn", 0, 30, 0, 0);
        check("post_rst_active", 32'(coin_active_o), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
